drop_filter_mp: RTL and testbench

DROP_FILTER_MP -- requirements
Module: drop_filter_mp

---
 rtl/drop_filter_mp.sv | 187 ++++++++++++++++++
 tb/tb_drop_filter_mp.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_filter_mp.sv
// Ingress drop filter: a fall-through FIFO feeds a HEAD/FWD/DROP FSM that checks the
// source-port MAC and IP checksum of each packet head and forwards, flags or discards it.
module drop_filter_mp #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int SRC_PORT_POS       = 16,
    parameter int FIFO_DEPTH_BITS    = 4,
    parameter int CNT_WIDTH          = 32,
    parameter int CHECK_CSUM         = 1
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESET,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    input  logic [48*NUM_PORTS-1:0]           mac_table,
    input  logic [15:0]                       exp_checksum,
    input  logic                              drop_enable,
    input  logic                              clear_counters,
    output logic [CNT_WIDTH-1:0]              pkt_count,
    output logic [CNT_WIDTH-1:0]              dropped_count,
    output logic [CNT_WIDTH-1:0]              wrong_mac_count,
    output logic [CNT_WIDTH-1:0]              bad_csum_count,
    output logic [NUM_PORTS:0]                last_drop_reason
);
    localparam int DW     = C_AXIS_DATA_WIDTH;
    localparam int SW     = C_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_AXIS_TUSER_WIDTH;
    localparam int BEAT_W = 1 + UW + SW + DW;
    localparam int DEPTH  = 2 ** FIFO_DEPTH_BITS;

    typedef enum logic [1:0] {HEAD, FWD, DROP} state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        return (en && (v != {CNT_WIDTH{1'b1}})) ? v + 1'b1 : v;
    endfunction

    logic [BEAT_W-1:0]          r_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   r_count;
    state_t                     r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]       r_pkt, r_drop, r_mac, r_csum;
    logic [NUM_PORTS:0]         r_reason;

    logic                       w_empty, w_nearly_full, w_push, w_pop, w_valid, w_first_pop;
    logic [BEAT_W-1:0]          w_head;
    logic [DW-1:0]              w_tdata;
    logic [SW-1:0]              w_tstrb;
    logic [UW-1:0]              w_tuser;
    logic                       w_tlast;
    logic [NUM_PORTS-1:0]       w_src, w_mac_fail;
    logic [47:0]                w_dst;
    logic                       w_checked, w_csum_fail, w_fail, w_discard;
    logic [NUM_PORTS:0]         w_reason;

    // Input FIFO: fall-through, head beat always visible at r_rd_ptr
    assign w_empty       = (r_count == '0);
    assign w_nearly_full = (r_count >= (FIFO_DEPTH_BITS+1)'(DEPTH - 1));
    assign S_AXIS_TREADY = ~w_nearly_full & ~AXI_RESET;
    assign w_push        = S_AXIS_TVALID & S_AXIS_TREADY;

    always_ff @(posedge AXI_ACLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head  = r_mem[r_rd_ptr];
    assign w_tdata = w_head[DW-1:0];
    assign w_tstrb = w_head[DW+SW-1:DW];
    assign w_tuser = w_head[DW+SW+UW-1:DW+SW];
    assign w_tlast = w_head[BEAT_W-1];

    // Head evaluation: MAC reasons are masked whenever the checksum already failed
    always_comb begin
        w_src = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_src[i] = w_tuser[SRC_PORT_POS + 2*i];
    end

    assign w_checked   = |w_src;
    assign w_dst       = w_tdata[255:208];
    assign w_csum_fail = w_checked && (CHECK_CSUM != 0) && (exp_checksum != w_tdata[63:48]);

    always_comb begin
        w_mac_fail = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_mac_fail[i] = !w_csum_fail && w_src[i] &&
                            (w_dst != mac_table[48*i +: 48]) && (w_dst != {48{1'b1}});
    end

    assign w_reason  = {w_mac_fail, w_csum_fail};
    assign w_fail    = |w_reason;
    assign w_discard = w_fail & drop_enable;

    // Output FSM
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) r_state <= HEAD;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_pop       = 1'b0;
        w_first_pop = 1'b0;
        case (r_state)
            HEAD: begin
                if (!w_empty) begin
                    if (w_discard) begin
                        w_pop = 1'b1;
                    end else begin
                        w_valid = 1'b1;
                        w_pop   = M_AXIS_TREADY;
                    end
                    w_first_pop = w_pop;
                    if (w_pop && !w_tlast)
                        w_state_nxt = w_discard ? DROP : FWD;
                end
            end
            FWD: begin
                w_valid = !w_empty;
                w_pop   = w_valid & M_AXIS_TREADY;
                if (w_pop && w_tlast) w_state_nxt = HEAD;
            end
            DROP: begin
                w_pop = !w_empty;
                if (w_pop && w_tlast) w_state_nxt = HEAD;
            end
            default: w_state_nxt = HEAD;
        endcase
    end

    assign M_AXIS_TVALID = w_valid & ~AXI_RESET;
    assign M_AXIS_TDATA  = w_tdata;
    assign M_AXIS_TSTRB  = w_tstrb;
    assign M_AXIS_TUSER  = w_tuser;
    assign M_AXIS_TLAST  = w_tlast;

    // Statistics: one update per packet, when its head beat leaves HEAD
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET || clear_counters) begin
            r_pkt    <= '0;
            r_drop   <= '0;
            r_mac    <= '0;
            r_csum   <= '0;
            r_reason <= '0;
        end else if (w_first_pop) begin
            r_pkt  <= sat_inc(r_pkt, 1'b1);
            r_drop <= sat_inc(r_drop, w_discard);
            r_mac  <= sat_inc(r_mac, |w_mac_fail);
            r_csum <= sat_inc(r_csum, w_csum_fail);
            if (w_fail) r_reason <= w_reason;
        end
    end

    assign pkt_count        = r_pkt;
    assign dropped_count    = r_drop;
    assign wrong_mac_count  = r_mac;
    assign bad_csum_count   = r_csum;
    assign last_drop_reason = r_reason;
endmodule

// File: tb/tb_drop_filter_mp.sv
// Bench for drop_filter_mp: vector table of single packets plus sequences for
// backpressure/nearly-full, counter saturation with clear, and reset mid-packet.
module tb_drop_filter_mp;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;
    localparam int NP = 4;
    localparam int CW = 4;
    localparam int BW = 1 + UW + SW + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_data;
    logic [SW-1:0]   s_strb;
    logic [UW-1:0]   s_user;
    logic            s_valid, s_last, s_ready;
    logic [DW-1:0]   m_data;
    logic [SW-1:0]   m_strb;
    logic [UW-1:0]   m_user;
    logic            m_valid, m_last, m_ready;
    logic [48*NP-1:0] mac_table;
    logic [15:0]     exp_csum;
    logic            drop_en, clr;
    logic [CW-1:0]   pkt_cnt, drop_cnt, mac_cnt, csum_cnt;
    logic [NP:0]     reason;

    always #5 clk = ~clk;

    drop_filter_mp #(
        .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(NP),
        .SRC_PORT_POS(16), .FIFO_DEPTH_BITS(4), .CNT_WIDTH(CW), .CHECK_CSUM(1)
    ) dut (
        .AXI_ACLK(clk), .AXI_RESET(rst),
        .S_AXIS_TDATA(s_data), .S_AXIS_TSTRB(s_strb), .S_AXIS_TUSER(s_user),
        .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
        .M_AXIS_TDATA(m_data), .M_AXIS_TSTRB(m_strb), .M_AXIS_TUSER(m_user),
        .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_ready),
        .mac_table(mac_table), .exp_checksum(exp_csum), .drop_enable(drop_en),
        .clear_counters(clr), .pkt_count(pkt_cnt), .dropped_count(drop_cnt),
        .wrong_mac_count(mac_cnt), .bad_csum_count(csum_cnt), .last_drop_reason(reason)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mon_exp;
    logic [BW-1:0] mon_got;
    bit occ_chk  = 1'b0;
    bit saw_full = 1'b0;
    int occ      = 0;

    typedef struct {
        int          nb;
        logic [UW-1:0] user;
        logic [47:0] dst;
        logic [15:0] csum;
        bit          den;
        bit          fwd;
        int          pkt, drp, mac, cs;
        logic [4:0]  rsn;
    } vec_t;
    vec_t vt[10];

    function automatic logic [47:0] mac_of(input int i);
        return 48'h0200_0000_0010 + 48'(i);
    endfunction

    function automatic logic [UW-1:0] port_user(input int i);
        logic [UW-1:0] u;
        u = '0;
        u[16 + 2*i] = 1'b1;
        u[7:0] = 8'hA5;
        return u;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            mon_got = {m_last, m_user, m_strb, m_data};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL beat_data: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
        if (occ_chk) begin
            check("s_tready_level", 64'(s_ready), 64'(occ < 15));
            if (!s_ready) saw_full = 1'b1;
            if (s_valid && s_ready) occ++;
            if (m_valid && m_ready) occ--;
        end
    end

    task automatic send_pkt(input int nb, input logic [UW-1:0] user, input logic [47:0] dst,
                            input logic [15:0] csum, input bit fwd, input bit trunc);
        for (int b = 0; b < nb; b++) begin
            logic [DW-1:0] d;
            int cyc;
            for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
            if (b == 0) begin
                d[255:208] = dst;
                d[63:48]   = csum;
            end
            s_data  = d;
            s_user  = user;
            s_strb  = '1;
            s_last  = (b == nb - 1) && !trunc;
            s_valid = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!s_ready && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            if (!s_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_tready_timeout: got 0 expected 1 within 300 cycles");
            end else if (fwd) begin
                exp_q.push_back({s_last, s_user, s_strb, s_data});
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [UW-1:0] cpu_user;
        cpu_user = '0;
        cpu_user[17] = 1'b1;
        for (int i = 0; i < NP; i++) mac_table[48*i +: 48] = mac_of(i);
        exp_csum = 16'hABCD;
        rst = 1'b1; clr = 1'b0; drop_en = 1'b0; m_ready = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_user = '0; s_strb = '0;

        //            nb  user           dst                csum      den fwd pkt drp mac cs rsn
        vt[0] = '{3, port_user(1), mac_of(1),         16'hABCD, 1'b0, 1'b1, 1, 0, 0, 0, 5'b00000};
        vt[1] = '{4, port_user(0), 48'h0200_0000_0099, 16'hABCD, 1'b1, 1'b0, 1, 1, 1, 0, 5'b00010};
        vt[2] = '{3, port_user(0), mac_of(0),         16'hABCD, 1'b1, 1'b1, 1, 0, 0, 0, 5'b00000};
        vt[3] = '{2, port_user(2), mac_of(2),         16'h1234, 1'b0, 1'b1, 1, 0, 0, 1, 5'b00001};
        vt[4] = '{2, port_user(1), 48'h0200_0000_0099, 16'h1234, 1'b1, 1'b0, 1, 1, 0, 1, 5'b00001};
        vt[5] = '{4, port_user(3), 48'hFFFF_FFFF_FFFF, 16'hABCD, 1'b1, 1'b1, 1, 0, 0, 0, 5'b00000};
        vt[6] = '{3, cpu_user,     48'h0200_0000_0099, 16'h1234, 1'b1, 1'b1, 1, 0, 0, 0, 5'b00000};
        vt[7] = '{1, port_user(2), 48'h0200_0000_0099, 16'hABCD, 1'b1, 1'b0, 1, 1, 1, 0, 5'b01000};
        vt[8] = '{1, port_user(0), mac_of(0),         16'hABCD, 1'b1, 1'b1, 1, 0, 0, 0, 5'b00000};
        vt[9] = '{2, port_user(3), mac_of(1),         16'hABCD, 1'b0, 1'b1, 1, 0, 1, 0, 5'b10000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_s_tready", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_pkt_count", 64'(pkt_cnt), 64'd0);
        check("reset_reason", 64'(reason), 64'd0);
        check("idle_m_tvalid", 64'(m_valid), 64'd0);
        check("idle_s_tready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            pulse_clear();
            drop_en = vt[i].den;
            send_pkt(vt[i].nb, vt[i].user, vt[i].dst, vt[i].csum, vt[i].fwd, 1'b0);
            drain();
            check($sformatf("v%0d_pkt_count", i),     64'(pkt_cnt),  64'(vt[i].pkt));
            check($sformatf("v%0d_dropped_count", i), 64'(drop_cnt), 64'(vt[i].drp));
            check($sformatf("v%0d_wrong_mac", i),     64'(mac_cnt),  64'(vt[i].mac));
            check($sformatf("v%0d_bad_csum", i),      64'(csum_cnt), 64'(vt[i].cs));
            check($sformatf("v%0d_reason", i),        64'(reason),   64'(vt[i].rsn));
        end

        // Backpressure: fill to nearly-full, then toggle TREADY across back-to-back packets
        pulse_clear();
        drop_en = 1'b0;
        occ = 0;
        saw_full = 1'b0;
        occ_chk = 1'b1;
        fork
            begin
                m_ready = 1'b0;
                repeat (25) @(posedge clk);
                for (int t = 0; t < 80; t++) begin
                    @(posedge clk); #1;
                    m_ready = ~m_ready;
                end
                m_ready = 1'b1;
            end
            begin
                for (int p = 0; p < 3; p++)
                    send_pkt(6, port_user(1), mac_of(1), 16'hABCD, 1'b1, 1'b0);
            end
        join
        drain();
        occ_chk = 1'b0;
        check("nearly_full_seen", 64'(saw_full), 64'd1);
        check("bp_pkt_count", 64'(pkt_cnt), 64'd3);

        // Saturation of 4-bit counters, then clear colliding with a drop
        pulse_clear();
        drop_en = 1'b1;
        for (int k = 0; k < 17; k++)
            send_pkt(1, port_user(0), 48'h0200_0000_0099, 16'hABCD, 1'b0, 1'b0);
        drain();
        check("sat_dropped_count", 64'(drop_cnt), 64'd15);
        check("sat_pkt_count", 64'(pkt_cnt), 64'd15);
        check("sat_wrong_mac", 64'(mac_cnt), 64'd15);
        send_pkt(1, port_user(0), 48'h0200_0000_0099, 16'hABCD, 1'b0, 1'b0);
        pulse_clear();
        @(negedge clk);
        check("clear_dropped_count", 64'(drop_cnt), 64'd0);
        check("clear_pkt_count", 64'(pkt_cnt), 64'd0);
        check("clear_reason", 64'(reason), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a packet
        drop_en = 1'b0;
        m_ready = 1'b0;
        send_pkt(2, port_user(2), mac_of(2), 16'hABCD, 1'b0, 1'b1);
        @(negedge clk);
        check("partial_head_valid", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_reset_s_tready", 64'(s_ready), 64'd0);
        check("in_reset_m_tvalid", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("post_reset_m_tvalid", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        send_pkt(2, port_user(2), mac_of(2), 16'hABCD, 1'b1, 1'b0);
        drain();
        check("post_reset_pkt_count", 64'(pkt_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
